// File: rtl/anim_sequencer.sv
// Animation phase sequencer: advances an N-bit phase once per frame (vsync rise)
// with run/pause, single-step, direction toggle and 1/2/4/8 step size.
module anim_sequencer #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int PHASE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               btn_pause,
    input  logic               btn_step,
    input  logic               btn_dir,
    input  logic [1:0]         speed,
    output logic [PHASE_W-1:0] anim_phase,
    output logic               frame_tick,
    output logic               paused,
    output logic               dir_down
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    localparam int BTN_PAUSE = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_DIR   = 2;

    logic [2:0] btn_raw;
    logic [2:0] btn_p0;
    logic [2:0] btn_p1;
    logic [2:0] btn_deb;
    logic [2:0] btn_deb_q;
    logic [2:0] btn_press;

    logic [1:0] speed_p0;
    logic [1:0] speed_p1;

    logic       vsync_q;
    logic       fe;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       advance;

    logic [PHASE_W-1:0] step_val;
    logic [PHASE_W-1:0] phase_nx;

    assign btn_raw = {btn_dir, btn_step, btn_pause};

    // Stage p0/p1: two-flop synchronisers for the asynchronous buttons and speed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p0   <= '0;
            btn_p1   <= '0;
            speed_p0 <= '0;
            speed_p1 <= '0;
        end else begin
            btn_p0   <= btn_raw;
            btn_p1   <= btn_p0;
            speed_p0 <= speed;
            speed_p1 <= speed_p0;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive clocks of disagreement; any agreement restarts the count.
    for (genvar i = 0; i < 3; i++) begin : g_debounce
        logic             deb_r;
        logic [CNT_W-1:0] cnt_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                deb_r <= 1'b0;
                cnt_r <= '0;
            end else if (btn_p1[i] == deb_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                deb_r <= btn_p1[i];
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end

        assign btn_deb[i] = deb_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_deb_q <= '0;
            vsync_q   <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            vsync_q   <= vsync;
        end
    end

    assign btn_press = btn_deb & ~btn_deb_q;
    assign fe        = vsync & ~vsync_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (btn_press[BTN_PAUSE]) state_nx = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (btn_press[BTN_PAUSE])     state_nx = ST_RUN;
                else if (btn_press[BTN_STEP]) state_nx = ST_STEP;
            end
            ST_STEP: begin
                if (btn_press[BTN_PAUSE]) state_nx = ST_RUN;
                else if (fe)              state_nx = ST_PAUSED;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    // Advance decision and direction both come from the pre-edge state.
    assign advance  = fe & ((state == ST_RUN) | (state == ST_STEP));
    assign step_val = {{(PHASE_W-1){1'b0}}, 1'b1} << speed_p1;
    assign phase_nx = dir_down ? (anim_phase - step_val) : (anim_phase + step_val);

    // Stage out: every output is a flop, so nothing combinational reaches the generator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            anim_phase <= '0;
            frame_tick <= 1'b0;
            paused     <= 1'b0;
            dir_down   <= 1'b0;
        end else begin
            state      <= state_nx;
            paused     <= (state_nx != ST_RUN);
            frame_tick <= advance;
            dir_down   <= dir_down ^ btn_press[BTN_DIR];
            if (advance) anim_phase <= phase_nx;
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with DEBOUNCE_CYCLES=4.
module tb_anim_sequencer;

    logic       clk;
    logic       reset;
    logic       vsync;
    logic       btn_pause;
    logic       btn_step;
    logic       btn_dir;
    logic [1:0] speed;
    logic [7:0] anim_phase;
    logic       frame_tick;
    logic       paused;
    logic       dir_down;

    int n_checks;
    int n_fail;

    anim_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .PHASE_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .btn_pause (btn_pause),
        .btn_step  (btn_step),
        .btn_dir   (btn_dir),
        .speed     (speed),
        .anim_phase(anim_phase),
        .frame_tick(frame_tick),
        .paused    (paused),
        .dir_down  (dir_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read there too.
    task automatic do_frame();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int which);
        @(negedge clk);
        case (which)
            0: btn_pause = 1'b1;
            1: btn_step  = 1'b1;
            default: btn_dir = 1'b1;
        endcase
        idle(10);
        btn_pause = 1'b0;
        btn_step  = 1'b0;
        btn_dir   = 1'b0;
        idle(10);
    endtask

    task automatic set_speed(input logic [1:0] s);
        @(negedge clk);
        speed = s;
        idle(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_checks++;
        if (anim_phase !== 8'd0 || frame_tick !== 1'b0 || paused !== 1'b0 || dir_down !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: phase=%0d tick=%b paused=%b dir=%b, want 0 0 0 0",
                     anim_phase, frame_tick, paused, dir_down);
        end
        reset = 1'b0;
        idle(3);
        n_checks++;
        if (anim_phase !== 8'd0 || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: phase=%0d paused=%b, want 0 0", anim_phase, paused);
        end
    endtask

    task automatic test_basic_frames();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vsync = 1'b1;
            #1;
            n_checks++;
            if (frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_early: frame %0d tick=%b, want 0", k, frame_tick);
            end
            @(negedge clk);
            vsync = 1'b0;
            n_checks++;
            if (anim_phase !== 8'(k) || frame_tick !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_frame: phase=%0d tick=%b, want %0d 1", anim_phase, frame_tick, k);
            end
            @(negedge clk);
            n_checks++;
            if (frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_width: frame %0d tick=%b, want 0", k, frame_tick);
            end
            idle(2);
        end
    endtask

    task automatic test_vsync_held();
        int ticks;
        ticks = 0;
        @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        vsync = 1'b0;
        idle(2);
        n_checks++;
        if (ticks !== 1 || anim_phase !== 8'd4) begin
            n_fail++;
            $display("FAIL vsync_held: ticks=%0d phase=%0d, want 1 4", ticks, anim_phase);
        end
    endtask

    task automatic test_wrap_and_dir();
        set_speed(2'd3);
        for (int i = 0; i < 30; i++) do_frame();
        set_speed(2'd1);
        for (int i = 0; i < 3; i++) do_frame();
        n_checks++;
        if (anim_phase !== 8'd250) begin
            n_fail++;
            $display("FAIL speed_climb: phase=%0d, want 250", anim_phase);
        end
        set_speed(2'd3);
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd2 || frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: phase=%0d tick=%b, want 2 1", anim_phase, frame_tick);
        end
        press_btn(2);
        n_checks++;
        if (dir_down !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_toggle: dir_down=%b, want 1", dir_down);
        end
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd250) begin
            n_fail++;
            $display("FAIL wrap_down8: phase=%0d, want 250", anim_phase);
        end
        for (int i = 0; i < 31; i++) do_frame();
        set_speed(2'd1);
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd0) begin
            n_fail++;
            $display("FAIL descend: phase=%0d, want 0", anim_phase);
        end
        set_speed(2'd0);
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd255 || dir_down !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_down1: phase=%0d dir=%b, want 255 1", anim_phase, dir_down);
        end
    endtask

    task automatic test_pause();
        int rises;
        logic prev;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_pause = (i % 2 == 0);
        end
        idle(12);
        n_checks++;
        if (paused !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_glitch: paused=%b, want 0", paused);
        end
        rises = 0;
        prev  = paused;
        @(negedge clk);
        btn_pause = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) btn_pause = 1'b0;
            @(negedge clk);
            if (paused === 1'b1 && prev === 1'b0) rises++;
            prev = paused;
        end
        n_checks++;
        if (rises !== 1 || paused !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_hold: rises=%0d paused=%b, want 1 1", rises, paused);
        end
        for (int i = 0; i < 2; i++) begin
            do_frame();
            n_checks++;
            if (anim_phase !== 8'd255 || frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL paused_frame: phase=%0d tick=%b, want 255 0", anim_phase, frame_tick);
            end
        end
    endtask

    task automatic test_step();
        press_btn(0);
        press_btn(2);
        n_checks++;
        if (paused !== 1'b0 || dir_down !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: paused=%b dir=%b, want 0 0", paused, dir_down);
        end
        for (int i = 0; i < 6; i++) do_frame();
        press_btn(0);
        n_checks++;
        if (anim_phase !== 8'd5 || paused !== 1'b1) begin
            n_fail++;
            $display("FAIL step_setup: phase=%0d paused=%b, want 5 1", anim_phase, paused);
        end
        press_btn(1);
        n_checks++;
        if (paused !== 1'b1) begin
            n_fail++;
            $display("FAIL step_pending_paused: paused=%b, want 1", paused);
        end
        for (int i = 0; i < 3; i++) begin
            do_frame();
            n_checks++;
            if (anim_phase !== 8'd6 || frame_tick !== (i == 0) || paused !== 1'b1) begin
                n_fail++;
                $display("FAIL step_frame%0d: phase=%0d tick=%b paused=%b, want 6 %b 1",
                         i, anim_phase, frame_tick, paused, (i == 0));
            end
        end
    endtask

    task automatic test_same_cycle();
        press_btn(0);
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd7 || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL run_to7: phase=%0d paused=%b, want 7 0", anim_phase, paused);
        end
        // Debounced press lands six edges after the raw level rises.
        @(negedge clk);
        btn_pause = 1'b1;
        idle(6);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        n_checks++;
        if (anim_phase !== 8'd8 || frame_tick !== 1'b1 || paused !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_with_fe: phase=%0d tick=%b paused=%b, want 8 1 1",
                     anim_phase, frame_tick, paused);
        end
        btn_pause = 1'b0;
        idle(10);
        press_btn(0);
        @(negedge clk);
        btn_dir = 1'b1;
        idle(6);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        n_checks++;
        if (anim_phase !== 8'd9 || dir_down !== 1'b1 || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_with_fe: phase=%0d dir=%b paused=%b, want 9 1 0",
                     anim_phase, dir_down, paused);
        end
        btn_dir = 1'b0;
        idle(10);
    endtask

    task automatic test_async_reset();
        press_btn(0);
        press_btn(1);
        n_checks++;
        if (paused !== 1'b1 || anim_phase !== 8'd9) begin
            n_fail++;
            $display("FAIL pending_setup: paused=%b phase=%0d, want 1 9", paused, anim_phase);
        end
        @(negedge clk);
        btn_pause = 1'b1;
        idle(3);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (anim_phase !== 8'd0 || frame_tick !== 1'b0 || paused !== 1'b0 || dir_down !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: phase=%0d tick=%b paused=%b dir=%b, want 0 0 0 0",
                     anim_phase, frame_tick, paused, dir_down);
        end
        btn_pause = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        do_frame();
        n_checks++;
        if (anim_phase !== 8'd1 || frame_tick !== 1'b1 || paused !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_frame: phase=%0d tick=%b paused=%b, want 1 1 0",
                     anim_phase, frame_tick, paused);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        vsync     = 1'b0;
        btn_pause = 1'b0;
        btn_step  = 1'b0;
        btn_dir   = 1'b0;
        speed     = 2'd0;

        test_reset();
        test_basic_frames();
        test_vsync_held();
        test_wrap_and_dir();
        test_pause();
        test_step();
        test_same_cycle();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
